// File: rtl/penalty_pkg.sv
// Shared types and goal-mouth geometry for the penalty-shot round controller.
package penalty_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AIM    = 3'd1,
    FLIGHT = 3'd2,
    RESULT = 3'd3,
    OVER   = 3'd4
  } state_e;

  localparam logic [11:0] GOAL_X_MIN = 12'd200;
  localparam logic [11:0] GOAL_X_MAX = 12'd599;
  localparam logic [11:0] GOAL_Y_MIN = 12'd100;
  localparam logic [11:0] GOAL_Y_MAX = 12'd249;
  localparam logic [12:0] KEEPER_W   = 13'd96;

  function automatic logic in_mouth(input logic [11:0] x, input logic [11:0] y);
    return (x >= GOAL_X_MIN) && (x <= GOAL_X_MAX) &&
           (y >= GOAL_Y_MIN) && (y <= GOAL_Y_MAX);
  endfunction

  // Widened to 13 bits so keeper_x + KEEPER_W never wraps near the right edge.
  function automatic logic is_goal(input logic [11:0] shot_x, input logic [11:0] keeper_x);
    logic [12:0] s;
    logic [12:0] k;
    s = {1'b0, shot_x};
    k = {1'b0, keeper_x};
    return (s < k) || (s >= k + KEEPER_W);
  endfunction

endpackage

// File: rtl/penalty_round_ctl_round_timer.sv
// Prescaler plus tick counter; expired marks the final cycle of a limit-tick interval.
module round_timer #(
  parameter int DIV = 400_000,
  parameter int TW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [TW-1:0] limit,
  output logic          expired
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic [TW-1:0] ticks;
  logic          tick;

  assign tick = (presc == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      presc <= '0;
      ticks <= '0;
    end else if (tick) begin
      presc <= '0;
      ticks <= ticks + TW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Asserted in the last cycle so the caller leaves exactly limit*DIV cycles after start.
  assign expired = tick && (ticks == limit - TW'(1));

endmodule

// File: rtl/penalty_round_ctl.sv
// Penalty-shot round sequencer: click -> aimed shot -> goal/save judgement -> score.
// Optional macro PENALTY_FLIGHT_WDT_EN adds a flight watchdog that scores a stuck shot as a miss.
module penalty_round_ctl
  import penalty_pkg::*;
#(
  parameter int ROUNDS               = 5,
  parameter int TICK_DIV             = 400_000,
  parameter int RESULT_TICKS         = 100,
  parameter int FLIGHT_TIMEOUT_TICKS = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic [11:0] keeper_xpos,
  input  logic        shot_done,
  output logic        shot_start,
  output logic [11:0] shot_xpos,
  output logic [11:0] shot_ypos,
  output logic        result_valid,
  output logic        result_goal,
  output logic [3:0]  score,
  output logic [3:0]  round,
  output logic        game_over
);

  localparam int TMAX = (RESULT_TICKS > FLIGHT_TIMEOUT_TICKS) ? RESULT_TICKS : FLIGHT_TIMEOUT_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  state_e  state_q, state_d;
  logic    ml_q, ml_qq;
  logic    click, aim_hit, goal_now;
  logic    tmr_start, tmr_expired, timeout;
  logic [TW-1:0] tmr_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      ml_q  <= 1'b0;
      ml_qq <= 1'b0;
    end else begin
      ml_q  <= mouse_left;
      ml_qq <= ml_q;
    end
  end

  assign click    = ml_q & ~ml_qq;
  assign aim_hit  = click && in_mouth(mouse_xpos, mouse_ypos);
  assign goal_now = is_goal(shot_xpos, keeper_xpos);

`ifdef PENALTY_FLIGHT_WDT_EN
  assign timeout = (state_q == FLIGHT) && tmr_expired;
`else
  assign timeout = 1'b0;
`endif

  // One timer serves both the RESULT hold and the flight watchdog; they never overlap.
  assign tmr_limit = (state_q == FLIGHT) ? TW'(FLIGHT_TIMEOUT_TICKS) : TW'(RESULT_TICKS);
  assign tmr_start = (state_d != state_q) && ((state_d == FLIGHT) || (state_d == RESULT));

  round_timer #(.DIV(TICK_DIV), .TW(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (tmr_start),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (click)                 state_d = AIM;
      AIM:     if (aim_hit)               state_d = FLIGHT;
      FLIGHT:  if (shot_done || timeout)  state_d = RESULT;
      RESULT:  if (tmr_expired)           state_d = (round == 4'(ROUNDS)) ? OVER : AIM;
      OVER:    if (click)                 state_d = AIM;
      default:                            state_d = IDLE;
    endcase
  end

  always_comb begin
    result_valid = 1'b0;
    game_over    = 1'b0;
    case (state_q)
      RESULT:  result_valid = 1'b1;
      OVER:    game_over    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shot_start  <= 1'b0;
      shot_xpos   <= '0;
      shot_ypos   <= '0;
      result_goal <= 1'b0;
      score       <= '0;
      round       <= '0;
    end else begin
      shot_start <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (click) begin
            score <= '0;
            round <= '0;
          end
        end
        AIM: begin
          if (aim_hit) begin
            shot_xpos  <= mouse_xpos;
            shot_ypos  <= mouse_ypos;
            shot_start <= 1'b1;
          end
        end
        FLIGHT: begin
          // shot_done takes priority over a coincident watchdog expiry
          if (shot_done) begin
            round       <= round + 4'd1;
            result_goal <= goal_now;
            if (goal_now) score <= score + 4'd1;
          end else if (timeout) begin
            round       <= round + 4'd1;
            result_goal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_penalty_round_ctl.sv
// Directed self-checking bench for penalty_round_ctl with shortened timing parameters.
module tb_penalty_round_ctl;

  logic        clk;
  logic        rst;
  logic        mouse_left;
  logic [11:0] mouse_xpos, mouse_ypos, keeper_xpos;
  logic        shot_done;
  logic        shot_start;
  logic [11:0] shot_xpos, shot_ypos;
  logic        result_valid, result_goal, game_over;
  logic [3:0]  score, round;

  int n_checks = 0;
  int n_err    = 0;

  penalty_round_ctl #(
    .ROUNDS(2), .TICK_DIV(2), .RESULT_TICKS(3), .FLIGHT_TIMEOUT_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .keeper_xpos(keeper_xpos),
    .shot_done(shot_done), .shot_start(shot_start),
    .shot_xpos(shot_xpos), .shot_ypos(shot_ypos),
    .result_valid(result_valid), .result_goal(result_goal),
    .score(score), .round(round), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Press, hold two edges, release; expects shot_start exactly 2 cycles after the press if accepted.
  task automatic do_click(input logic [11:0] x, input logic [11:0] y, input logic exp);
    mouse_xpos = x;
    mouse_ypos = y;
    mouse_left = 1'b1;
    step;
    chk("start_early", shot_start, 0);
    step;
    chk("start_pulse", shot_start, exp);
    if (exp) begin
      chk("shot_xpos", shot_xpos, x);
      chk("shot_ypos", shot_ypos, y);
    end
    step;
    chk("start_once", shot_start, 0);
    mouse_left = 1'b0;
    step;
  endtask

  task automatic finish_shot(input logic goal, input int exp_score, input int exp_round, input logic over);
    int n;
    shot_done = 1'b1;
    step;
    shot_done = 1'b0;
    chk("result_valid", result_valid, 1);
    chk("result_goal", result_goal, goal);
    chk("score", score, exp_score);
    chk("round", round, exp_round);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step;
      if (!result_valid) break;
      n++;
    end
    chk("result_len", n, 6);
    chk("game_over", game_over, over);
  endtask

  initial begin
    rst = 1'b1; mouse_left = 1'b0; mouse_xpos = '0; mouse_ypos = '0;
    keeper_xpos = 12'd100; shot_done = 1'b0;
    step; step;
    rst = 1'b0;
    chk("rst_shot_start", shot_start, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_score", score, 0);
    chk("rst_round", round, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_shot_xpos", shot_xpos, 0);

    // Game 1: IDLE -> AIM, miss-click outside mouth, goal, then save
    do_click(12'd0, 12'd0, 1'b0);
    do_click(12'd10, 12'd10, 1'b0);
    do_click(12'd300, 12'd150, 1'b1);
    finish_shot(1'b1, 1, 1, 1'b0);

    keeper_xpos = 12'd250;
    do_click(12'd300, 12'd150, 1'b1);
    do_click(12'd400, 12'd150, 1'b0);
    chk("flight_click_ignored", shot_xpos, 300);
    finish_shot(1'b0, 1, 2, 1'b1);

    shot_done = 1'b1; step; shot_done = 1'b0; step;
    chk("over_stray_valid", result_valid, 0);
    chk("over_stray_score", score, 1);
    chk("over_stray_round", round, 2);
    chk("over_hold", game_over, 1);

    do_click(12'd10, 12'd10, 1'b0);
    chk("restart_score", score, 0);
    chk("restart_round", round, 0);
    chk("restart_over", game_over, 0);

    shot_done = 1'b1; step; shot_done = 1'b0; step;
    chk("aim_stray_valid", result_valid, 0);
    chk("aim_stray_round", round, 0);

    // Game 2: keeper edge boundaries
    do_click(12'd346, 12'd150, 1'b1);
    finish_shot(1'b1, 1, 1, 1'b0);
    do_click(12'd345, 12'd150, 1'b1);
    finish_shot(1'b0, 1, 2, 1'b1);

    // Game 3: mouth corner accepted
    do_click(12'd0, 12'd0, 1'b0);
    do_click(12'd599, 12'd249, 1'b1);

`ifdef PENALTY_FLIGHT_WDT_EN
    begin
      int n;
      n = 0;
      for (int i = 0; i < 30; i++) begin
        if (result_valid) break;
        step;
        n++;
      end
      chk("wdt_latency", n, 8);
      chk("wdt_goal", result_goal, 0);
      chk("wdt_round", round, 1);
      chk("wdt_score", score, 0);
      for (int i = 0; i < 20; i++) begin
        if (!result_valid) break;
        step;
      end
      chk("wdt_back_to_aim", result_valid, 0);
      do_click(12'd300, 12'd150, 1'b1);
    end
`endif

    // Reset while in FLIGHT
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_shot_start", shot_start, 0);
    chk("midrst_shot_xpos", shot_xpos, 0);
    chk("midrst_shot_ypos", shot_ypos, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_goal", result_goal, 0);
    chk("midrst_score", score, 0);
    chk("midrst_round", round, 0);
    chk("midrst_over", game_over, 0);
    shot_done = 1'b1; step; shot_done = 1'b0; step;
    chk("idle_stray_valid", result_valid, 0);
    chk("no_reissue", shot_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/penalty_round_ctl.md
# penalty_round_ctl

Game-round sequencer for the penalty shot. It turns mouse clicks into aimed shots and hands each shot to the ball-motion datapath through a start/done handshake. It then judges goal versus save against the keeper position, keeps score and round count, and declares game over after a fixed number of shots. It sits between the mouse interface and the ball/keeper drawing controllers.

## Interface
- ROUNDS, 5, shots per game; range 1..15
- TICK_DIV, 400_000, clk cycles per timer tick (10 ms at 40 MHz)
- RESULT_TICKS, 100, ticks the result is held (1 s)
- FLIGHT_TIMEOUT_TICKS, 300, watchdog limit in ticks; used only with the macro enabled
- clk  in  1  system clock (40 MHz)
- rst  in  1  reset; synchronous and active-high. One clock; reset is synchronous and active-high.
- mouse_left  in  1  left-button level from the mouse interface
- mouse_xpos, mouse_ypos  in  12 each  cursor position in pixels
- keeper_xpos  in  12  keeper left edge in pixels
- shot_done  in  1  one-cycle pulse from the ball datapath: ball reached its target
- shot_start  out  1  one-cycle pulse that launches the ball
- shot_xpos, shot_ypos  out  12 each  latched aim point, stable from shot_start until the next shot
- result_valid  out  1  high for the whole RESULT state
- result_goal  out  1  1 = goal, 0 = saved or missed; meaningful while result_valid is high
- score  out  4  goals this game
- round  out  4  completed shots this game
- game_over  out  1  high in OVER

## Operation
- Click detection: mouse_left is registered once. A click is the first cycle in which the registered value is 1 and the previous registered value was 0. Held buttons do not repeat.
- IDLE: a click moves to AIM. score and round are cleared.
- AIM: a click inside the goal mouth (GOAL_X_MIN ≤ x ≤ GOAL_X_MAX and GOAL_Y_MIN ≤ y ≤ GOAL_Y_MAX, inclusive) latches the shot position, pulses shot_start and moves to FLIGHT. Clicks outside the mouth are ignored.
- FLIGHT: on shot_done, goal = 1 if shot_xpos < keeper_xpos or shot_xpos ≥ keeper_xpos + KEEPER_W. The comparison is 13-bit, with no wrap. keeper_xpos is sampled in the shot_done cycle. round increments; score increments on a goal. Next state is RESULT.
- RESULT: held for RESULT_TICKS ticks. The tick prescaler restarts on entry. Then the block goes to OVER if round == ROUNDS, otherwise back to AIM.
- OVER: game_over is high. A click clears score and round and moves to AIM.
- Ignored inputs: clicks in FLIGHT or RESULT; shot_done in any state other than FLIGHT.

## Timing
- Reset values: every output is 0; state = IDLE; prescaler = 0.
- Click latency: a click detected at clock edge k gives shot_start = 1 during cycle k+1, with shot_xpos/ypos already valid. Mouse-edge-to-shot_start is 2 cycles.
- shot_done detected at edge k: state is RESULT in cycle k+1, with result_valid, result_goal, score and round all updated.
- RESULT lasts exactly RESULT_TICKS × TICK_DIV cycles.
- Reset mid-game: rst asserted in any state returns to IDLE at the next edge. shot_start is not reissued.

## Configuration
- PENALTY_FLIGHT_WDT_EN defined: a watchdog counts ticks in FLIGHT.
  - After FLIGHT_TIMEOUT_TICKS ticks without shot_done, the shot is scored as a miss (result_goal = 0), round increments, and the state moves to RESULT.
  - If shot_done arrives in the same cycle as the timeout, shot_done wins.
- Macro undefined: FLIGHT waits for shot_done indefinitely, and FLIGHT_TIMEOUT_TICKS is unused.

## Structure
- Package penalty_pkg holds:
  - state enum (IDLE, AIM, FLIGHT, RESULT, OVER)
  - GOAL_X_MIN = 200, GOAL_X_MAX = 599, GOAL_Y_MIN = 100, GOAL_Y_MAX = 249
  - KEEPER_W = 96
- Sub-module round_timer:
  - prescaler plus tick counter, with inputs start, limit, and output expired
  - shared by the RESULT hold and the watchdog, since the two are never active together

## Test plan
(TICK_DIV = 2, RESULT_TICKS = 3, ROUNDS = 2, FLIGHT_TIMEOUT_TICKS = 5 for the bench)
- Reset, then a click at (0,0) → AIM. A click at (10,10) → no shot_start. A click at (300,150) → one shot_start pulse 2 cycles after the mouse edge, shot_xpos = 300, shot_ypos = 150.
- keeper_xpos = 100, shot at x = 300, shot_done → result_goal = 1, score = 1, round = 1; result_valid high for 6 cycles, then AIM.
- keeper_xpos = 250, shot at x = 300, shot_done → result_goal = 0, score unchanged.
- Boundaries with keeper_xpos = 250: shot x = 346 → goal; x = 345 → save; click at x = 599, y = 249 → accepted.
- Second shot → game_over = 1. Clicks and stray shot_done pulses are ignored until a click in OVER → score = 0, round = 0, AIM.
- With PENALTY_FLIGHT_WDT_EN, no shot_done → miss after 10 cycles in FLIGHT. rst asserted in FLIGHT → all outputs 0 next cycle.
